rs_alloc_issue_ctrl: RTL
========================

Name: rs_alloc_issue_ctrl

Overview:
- Controls one ALU reservation station (RS): owns the per-entry busy bits and relative age of every entry.
- Dispatch side: grants up to two entry addresses per cycle and raises stall when capacity is short.
- Issue side: selects the oldest operand-ready entry through a valid/ready handshake to the ALU.
- Sits between the dispatch stage and the RS data array; a mispredict flush empties it.

Parameters:
- ENT_NUM, 8, number of RS entries (2..16).
- ENT_SEL, 3, entry address width, clog2(ENT_NUM).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- dp_req1  in  1  dispatch slot 1 requests an entry.
- dp_req2  in  1  dispatch slot 2 requests an entry; counted only when dp_req1=1.
- dp_stall  out  1  requested count exceeds free entries this cycle.
- dp_we1  out  1  slot 1 write enable to the RS array.
- dp_we2  out  1  slot 2 write enable to the RS array.
- dp_waddr1  out  ENT_SEL  entry address granted to slot 1.
- dp_waddr2  out  ENT_SEL  entry address granted to slot 2.
- ent_ready  in  ENT_NUM  per-entry "all operands ready" from the wakeup logic.
- iss_valid  out  1  an entry is offered to the ALU.
- iss_addr  out  ENT_SEL  address of the offered entry.
- iss_ready  in  1  ALU accepts this cycle.
- flush  in  1  mispredict; kill all entries.
- busy_vec  out  ENT_NUM  registered busy bits.
- free_cnt  out  ENT_SEL+1  number of clear busy bits.

Behaviour:
- State:
  - busy[ENT_NUM] register.
  - age[ENT_NUM][ENT_NUM] register; age[i][j]=1 means i is older than j; the diagonal is ignored.
  - The only sequential elements are these registers; every output is combinational from them and the inputs (zero-cycle grant/select).
- Reset (rst_n=0, async): busy=0 and age=0. Resulting outputs: dp_stall=0, dp_we1/2=0, dp_waddr1/2=0, iss_valid=0, iss_addr=0, busy_vec=0, free_cnt=ENT_NUM.
- Allocation:
  - reqnum = dp_req1 + (dp_req1 & dp_req2), range 0..2.
  - free1 = lowest-index entry with busy=0; free2 = next lowest above free1. Both are computed from the registered busy only.
  - dp_stall = (reqnum > free_cnt).
  - Stall is all-or-nothing: when dp_stall=1, dp_we1=dp_we2=0.
  - Otherwise dp_we1=dp_req1, dp_we2=dp_req1&dp_req2, dp_waddr1=free1, dp_waddr2=free2.
  - When an address is not valid, dp_waddr1/dp_waddr2 are driven 0.
- Age update on allocation at the clock edge:
  - New entry k becomes youngest: row age[k][*]=0, and column age[i][k]=1 for every i still busy after this edge.
  - With a dual allocation, slot 1 is older than slot 2: age[free1][free2]=1, age[free2][free1]=0.
- Issue select:
  - Candidate set: cand = busy & ent_ready.
  - Entry i is selected if cand[i]=1 and age[i][j]=1 for every other j with cand[j]=1.
  - iss_valid = |cand & ~flush; iss_addr = the selected index, or 0 when iss_valid=0.
  - Handshake: iss_valid & iss_ready clears busy[iss_addr] at the edge.
  - iss_valid=1 with iss_ready=0 holds no state: the selection is recomputed each cycle, and an older entry that becomes ready preempts the offer.
- Same-cycle events:
  - An entry issued in cycle N is not reallocated in cycle N; it is free from N+1.
  - An entry allocated in cycle N is not a candidate before N+1.
  - Allocation and issue in the same cycle touch disjoint entries, so both take effect.
- Flush:
  - flush=1 forces dp_we1/2=0 and iss_valid=0, regardless of requests or handshakes.
  - At the next edge busy=0 and age=0; any dispatch or issue in that cycle is discarded.
  - dp_stall is still computed normally during flush.
- Full: free_cnt=0 asserts dp_stall for any reqnum≥1; reqnum=0 never stalls.
- Async reset mid-operation: immediate clear, same values as at reset.

Decomposition:
- constants.vh gains the RS_ENT_NUM and RS_ENT_SEL defines; the parameters default to these.
- Sub-module rs_oldest_sel: combinational, inputs cand and age, outputs valid and addr. It is reusable by the other RS schedulers.
- Free-entry search and popcount stay inline.

Test Plan:
- Reset, then dp_req1=dp_req2=1 for four cycles with ent_ready=0 -> grants (0,1), (2,3), (4,5), (6,7); busy_vec=8'hFF, free_cnt=0.
- Full RS, dp_req1=1 -> dp_stall=1, dp_we1=0; issue entry 3 (ent_ready[3]=1, iss_ready=1) -> next cycle dp_waddr1=3, dp_stall=0.
- Allocate 5 then 2 then 6 in separate cycles, then set ent_ready=8'hFF with iss_ready=1 -> iss_addr sequence 5, 2, 6.
- free_cnt=1 with dual request -> dp_stall=1, neither write enable; a single request in the same state -> granted.
- Hold iss_ready=0 with entry 4 offered, then raise ent_ready of older entry 1 -> iss_addr switches to 1, busy unchanged.
- Six entries busy, flush=1 together with dp_req1=1 and iss_ready=1 -> dp_we1=0, iss_valid=0; next cycle busy_vec=0, free_cnt=8.

Source files
------------

// File: rtl/rs_alloc_issue_ctrl_pkg.sv
// Shared sizing constants and small types for the ALU reservation-station controller
// and the other RS schedulers built on the same oldest-first selector.
package rs_alloc_issue_ctrl_pkg;

    localparam int RS_ENT_NUM = 8;
    localparam int RS_ENT_SEL = 3;

    // Number of dispatch slots requesting an entry this cycle (0..2).
    typedef logic [1:0] req_cnt_t;

endpackage

// File: rtl/rs_oldest_sel.sv
// Combinational oldest-first picker: among candidate entries, returns the one
// that the age matrix marks older than every other candidate.
module rs_oldest_sel #(
    parameter int ENT_NUM = 8,
    parameter int ENT_SEL = 3
) (
    input  logic [ENT_NUM-1:0]              cand_i,
    input  logic [ENT_NUM-1:0][ENT_NUM-1:0] age_i,
    output logic                            valid_o,
    output logic [ENT_SEL-1:0]              addr_o
);

    logic [ENT_NUM-1:0] win;

    // A candidate wins when it is older than all other candidates; the age
    // order among busy entries is total, so at most one entry can win.
    always_comb begin
        win     = '0;
        valid_o = |cand_i;
        addr_o  = '0;
        for (int i = 0; i < ENT_NUM; i++) begin
            win[i] = cand_i[i];
            for (int j = 0; j < ENT_NUM; j++) begin
                if ((i != j) && cand_i[j] && !age_i[i][j]) begin
                    win[i] = 1'b0;
                end
            end
        end
        for (int i = ENT_NUM - 1; i >= 0; i--) begin
            if (win[i]) begin
                addr_o = ENT_SEL'(i);
            end
        end
    end

endmodule

// File: rtl/rs_alloc_issue_ctrl.sv
// ALU reservation-station controller: tracks busy bits and relative age, grants
// up to two free entries per cycle to dispatch and offers the oldest ready entry to the ALU.
module rs_alloc_issue_ctrl
    import rs_alloc_issue_ctrl_pkg::*;
#(
    parameter int ENT_NUM = RS_ENT_NUM,
    parameter int ENT_SEL = RS_ENT_SEL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dp_req1,
    input  logic               dp_req2,
    output logic               dp_stall,
    output logic               dp_we1,
    output logic               dp_we2,
    output logic [ENT_SEL-1:0] dp_waddr1,
    output logic [ENT_SEL-1:0] dp_waddr2,
    input  logic [ENT_NUM-1:0] ent_ready,
    output logic               iss_valid,
    output logic [ENT_SEL-1:0] iss_addr,
    input  logic               iss_ready,
    input  logic               flush,
    output logic [ENT_NUM-1:0] busy_vec,
    output logic [ENT_SEL:0]   free_cnt
);

    logic [ENT_NUM-1:0]              busy_q, busy_d;
    logic [ENT_NUM-1:0][ENT_NUM-1:0] age_q, age_d;
    logic [ENT_SEL-1:0]              free1, free2;
    logic                            free1_vld, free2_vld;
    logic [ENT_SEL:0]                free_cnt_w;
    req_cnt_t                        reqnum;
    logic [ENT_NUM-1:0]              cand;
    logic                            sel_valid;
    logic [ENT_SEL-1:0]              sel_addr;
    logic                            iss_fire;

    // Free-entry search and popcount look only at the registered busy bits, so an
    // entry issued this cycle is never handed out again until the next one.
    always_comb begin
        free1      = '0;
        free2      = '0;
        free1_vld  = 1'b0;
        free2_vld  = 1'b0;
        free_cnt_w = '0;
        for (int i = 0; i < ENT_NUM; i++) begin
            if (!busy_q[i]) begin
                free_cnt_w = free_cnt_w + (ENT_SEL + 1)'(1);
                if (!free1_vld) begin
                    free1     = ENT_SEL'(i);
                    free1_vld = 1'b1;
                end else if (!free2_vld) begin
                    free2     = ENT_SEL'(i);
                    free2_vld = 1'b1;
                end
            end
        end
    end

    assign reqnum    = {dp_req1 & dp_req2, dp_req1 & ~dp_req2};
    assign dp_stall  = (ENT_SEL + 1)'(reqnum) > free_cnt_w;
    assign dp_we1    = dp_req1 & ~dp_stall & ~flush;
    assign dp_we2    = dp_we1 & dp_req2;
    assign dp_waddr1 = free1_vld ? free1 : '0;
    assign dp_waddr2 = free2_vld ? free2 : '0;

    assign cand = busy_q & ent_ready;

    rs_oldest_sel #(
        .ENT_NUM (ENT_NUM),
        .ENT_SEL (ENT_SEL)
    ) u_oldest_sel (
        .cand_i  (cand),
        .age_i   (age_q),
        .valid_o (sel_valid),
        .addr_o  (sel_addr)
    );

    assign iss_valid = sel_valid & ~flush;
    assign iss_addr  = iss_valid ? sel_addr : '0;
    assign iss_fire  = iss_valid & iss_ready;

    assign busy_vec = busy_q;
    assign free_cnt = free_cnt_w;

    // Slot 1 is processed before slot 2: slot 2's row clear removes the "younger
    // than slot 1" bit slot 1's column wrote, and slot 2's column marks slot 1 older.
    always_comb begin
        busy_d = busy_q;
        age_d  = age_q;
        if (iss_fire) begin
            busy_d[iss_addr] = 1'b0;
        end
        if (dp_we1) begin
            busy_d[free1] = 1'b1;
        end
        if (dp_we2) begin
            busy_d[free2] = 1'b1;
        end
        if (dp_we1) begin
            for (int j = 0; j < ENT_NUM; j++) begin
                age_d[free1][j] = 1'b0;
            end
            for (int i = 0; i < ENT_NUM; i++) begin
                age_d[i][free1] = busy_d[i];
            end
        end
        if (dp_we2) begin
            for (int j = 0; j < ENT_NUM; j++) begin
                age_d[free2][j] = 1'b0;
            end
            for (int i = 0; i < ENT_NUM; i++) begin
                age_d[i][free2] = busy_d[i];
            end
        end
        if (flush) begin
            busy_d = '0;
            age_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            age_q  <= '0;
        end else begin
            busy_q <= busy_d;
            age_q  <= age_d;
        end
    end

endmodule
